// File: rtl/adaptive_traffic_controller.sv
// rtl/adaptive_traffic_controller.sv - density-driven traffic light sequencer
// with emergency-vehicle preemption and red-light violation capture.
module adaptive_traffic_controller #(
  parameter int N_ROADS   = 4,
  parameter int LEVELS    = 3,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [N_ROADS*LEVELS-1:0]    density,
  input  logic [N_ROADS-1:0]           siren,
  input  logic [N_ROADS-1:0]           violation,
  output logic [3*N_ROADS-1:0]         lights,
  output logic [$clog2(N_ROADS)-1:0]   active_road,
  output logic [2:0]                   state,
  output logic [N_ROADS-1:0]           camera
);

  localparam int AW = $clog2(N_ROADS);
  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam int LW = $clog2(LEVELS + 1);
  localparam int PC = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int CW = $clog2(PC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_GREEN   = 3'd2,
    S_YELLOW  = 3'd3,
    S_ALL_RED = 3'd4,
    S_PREEMPT = 3'd5
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     active_q;
  logic [AW-1:0]     last_q;
  logic [TW-1:0]     timer_q;
  logic [CW-1:0]     cnt_q;
  logic [N_ROADS-1:0] camera_q;

  logic [LW-1:0]      lvl [N_ROADS];
  logic               any_level;
  logic               other_siren;
  logic               higher_other;
  logic [AW-1:0]      siren_idx;
  logic [AW-1:0]      sel_road_d;
  logic [LW-1:0]      sel_lvl;
  logic [AW-1:0]      idx;
  logic               green_done;
  logic               serving;
  logic [N_ROADS-1:0] red_mask;

  always_comb begin
    for (int i = 0; i < N_ROADS; i++) begin
      lvl[i] = '0;
      for (int b = 0; b < LEVELS; b++) begin
        lvl[i] = lvl[i] + LW'(density[LEVELS*i + b]);
      end
    end
  end

  always_comb begin
    any_level    = 1'b0;
    other_siren  = 1'b0;
    higher_other = 1'b0;
    siren_idx    = '0;
    for (int i = N_ROADS - 1; i >= 0; i--) begin
      if (siren[i]) siren_idx = AW'(i);
    end
    for (int i = 0; i < N_ROADS; i++) begin
      if (lvl[i] != '0) any_level = 1'b1;
      if (i != int'(active_q)) begin
        if (siren[i]) other_siren = 1'b1;
        if (lvl[i] > lvl[active_q]) higher_other = 1'b1;
      end
    end
    // Rotating scan from the road after the last served one; only a strictly
    // higher level displaces an earlier candidate, so ties favour rotation order.
    idx        = (last_q == AW'(N_ROADS - 1)) ? '0 : last_q + 1'b1;
    sel_road_d = idx;
    sel_lvl    = lvl[idx];
    for (int j = 1; j < N_ROADS; j++) begin
      idx = (idx == AW'(N_ROADS - 1)) ? '0 : idx + 1'b1;
      if (lvl[idx] > sel_lvl) begin
        sel_road_d = idx;
        sel_lvl    = lvl[idx];
      end
    end
    green_done = (timer_q >= TW'(MAX_GREEN - 1)) ||
                 ((timer_q >= TW'(MIN_GREEN - 1)) &&
                  ((lvl[active_q] == '0) || higher_other));
  end

  always_comb begin
    lights   = '0;
    red_mask = '0;
    serving  = (state_q == S_GREEN) || (state_q == S_YELLOW) || (state_q == S_PREEMPT);
    for (int i = 0; i < N_ROADS; i++) begin
      if (serving && (active_q == AW'(i))) begin
        lights[3*i +: 3] = (state_q == S_YELLOW) ? 3'b010 : 3'b001;
      end else begin
        lights[3*i +: 3] = 3'b100;
        red_mask[i]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      last_q   <= AW'(N_ROADS - 1);
      timer_q  <= '0;
      cnt_q    <= '0;
      camera_q <= '0;
    end else begin
      camera_q <= violation & red_mask;
      case (state_q)
        S_IDLE: begin
          if (|siren) begin
            state_q  <= S_PREEMPT;
            active_q <= siren_idx;
          end else if (any_level) begin
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          active_q <= sel_road_d;
          timer_q  <= '0;
          state_q  <= S_GREEN;
        end
        S_GREEN: begin
          if (timer_q != TW'(MAX_GREEN)) timer_q <= timer_q + 1'b1;
          if (siren[active_q]) begin
            state_q <= S_PREEMPT;
          end else if (other_siren || green_done) begin
            state_q <= S_YELLOW;
            cnt_q   <= '0;
            last_q  <= active_q;
          end
        end
        S_YELLOW: begin
          if (cnt_q == CW'(YELLOW - 1)) begin
            state_q <= S_ALL_RED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ALL_RED: begin
          if (cnt_q == CW'(ALL_RED - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PREEMPT: begin
          if (!siren[active_q]) begin
            state_q <= S_YELLOW;
            cnt_q   <= '0;
            last_q  <= active_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign active_road = active_q;
  assign camera      = camera_q;

endmodule

// File: tb/tb_adaptive_traffic_controller.sv
// tb/tb_adaptive_traffic_controller.sv - directed scenarios plus randomized
// run against a countdown-based behavioural model of the intersection.
module tb_adaptive_traffic_controller;
  localparam int N = 4, L = 3, MING = 4, MAXG = 16, YEL = 2, AR = 1;
  localparam logic [11:0] ALL_RED_L = 12'b100100100100;

  logic        clock = 1'b0;
  logic        clear;
  logic [11:0] density;
  logic [3:0]  siren, violation;
  logic [11:0] lights;
  logic [1:0]  active_road;
  logic [2:0]  state;
  logic [3:0]  camera;

  int total = 0;
  int bad   = 0;

  int       m_st, m_road, m_gcnt, m_left, m_last;
  bit [3:0] m_cam;

  adaptive_traffic_controller #(
    .N_ROADS(N), .LEVELS(L), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW(YEL), .ALL_RED(AR)
  ) dut (
    .clock(clock), .clear(clear), .density(density), .siren(siren),
    .violation(violation), .lights(lights), .active_road(active_road),
    .state(state), .camera(camera)
  );

  initial forever #5 clock = ~clock;

  function automatic int road_lvl(int r);
    return $countones(density[3*r +: 3]);
  endfunction

  function automatic logic [11:0] m_lights();
    logic [11:0] v;
    for (int r = 0; r < N; r++) begin
      if ((m_st == 2 || m_st == 5) && r == m_road) v[3*r +: 3] = 3'b001;
      else if (m_st == 3 && r == m_road)           v[3*r +: 3] = 3'b010;
      else                                          v[3*r +: 3] = 3'b100;
    end
    return v;
  endfunction

  // Reference: phases counted down from their nominal length, levels by popcount.
  task automatic model_step();
    logic [11:0] lt;
    int nst, best, best_lvl, r;
    bit others, higher;
    lt  = m_lights();
    nst = m_st;
    if (clear) begin
      m_st = 0; m_road = 0; m_gcnt = 0; m_last = N - 1; m_cam = '0;
    end else begin
      for (int k = 0; k < N; k++) m_cam[k] = violation[k] & lt[3*k+2];
      others = 0; higher = 0;
      for (int k = 0; k < N; k++) begin
        if (k != m_road && siren[k]) others = 1;
        if (k != m_road && road_lvl(k) > road_lvl(m_road)) higher = 1;
      end
      case (m_st)
        0: begin
          if (siren != 0) begin
            nst = 5;
            for (int k = N - 1; k >= 0; k--) if (siren[k]) m_road = k;
          end else begin
            for (int k = 0; k < N; k++) if (road_lvl(k) > 0) nst = 1;
          end
        end
        1: begin
          best = 0; best_lvl = -1;
          for (int k = 0; k < N; k++) begin
            r = (m_last + 1 + k) % N;
            if (road_lvl(r) > best_lvl) begin best = r; best_lvl = road_lvl(r); end
          end
          m_road = best; m_gcnt = 0; nst = 2;
        end
        2: begin
          m_gcnt++;
          if (siren[m_road]) nst = 5;
          else if (others || m_gcnt >= MAXG ||
                   (m_gcnt >= MING && (road_lvl(m_road) == 0 || higher))) begin
            nst = 3; m_left = YEL; m_last = m_road;
          end
        end
        3: begin m_left--; if (m_left == 0) begin nst = 4; m_left = AR; end end
        4: begin m_left--; if (m_left == 0) nst = 0; end
        5: if (!siren[m_road]) begin nst = 3; m_left = YEL; m_last = m_road; end
        default: nst = 0;
      endcase
      m_st = nst;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; density = '0; siren = '0; violation = '0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; density = 12'hfff; siren = 4'hf; violation = 4'hf;
    tick(); tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (active_road !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", active_road); end
    total++; if (lights !== ALL_RED_L) begin bad++; $display("FAIL reset_lights got=%b exp=%b", lights, ALL_RED_L); end
    total++; if (camera !== 4'b0) begin bad++; $display("FAIL reset_camera got=%b exp=0000", camera); end
    clear = 1'b0; density = '0; siren = '0; violation = '0;
  endtask

  task automatic test_single_road();
    do_clear();
    density = 12'b000_011_000_000;
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL single_select got=%0d exp=1", state); end
    tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL single_green got=%0d exp=2", state); end
    total++; if (lights !== 12'b100001100100) begin bad++; $display("FAIL single_lights got=%b exp=100001100100", lights); end
    total++; if (active_road !== 2'd2) begin bad++; $display("FAIL single_active got=%0d exp=2", active_road); end
  endtask

  task automatic test_min_green();
    int exp_st[8] = '{2, 2, 3, 3, 4, 0, 1, 2};
    do_clear();
    density = 12'b000_000_000_001;
    tick(); tick(); tick();
    total++; if (state !== 3'd2 || active_road !== 2'd0) begin bad++; $display("FAIL min_green_c2 got=%0d/%0d exp=2/0", state, active_road); end
    density = 12'b000_000_111_001;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (state !== 3'(exp_st[k])) begin bad++; $display("FAIL min_green_seq step=%0d got=%0d exp=%0d", k, state, exp_st[k]); end
      if (k == 2) begin
        total++; if (lights !== 12'b100100100010) begin bad++; $display("FAIL min_green_yellow got=%b exp=100100100010", lights); end
      end
    end
    total++; if (active_road !== 2'd1) begin bad++; $display("FAIL min_green_next got=%0d exp=1", active_road); end
  endtask

  task automatic test_max_green();
    do_clear();
    density = 12'hfff;
    for (int r = 0; r < 3; r++) begin
      tick();
      total++; if (state !== 3'd1) begin bad++; $display("FAIL max_select road=%0d got=%0d exp=1", r, state); end
      for (int c = 0; c < MAXG; c++) begin
        tick();
        total++; if (state !== 3'd2 || active_road !== 2'(r)) begin bad++; $display("FAIL max_green road=%0d cyc=%0d got=%0d/%0d exp=2/%0d", r, c, state, active_road, r); end
      end
      for (int c = 0; c < 4; c++) begin
        tick();
        total++; if (state !== ((c < 2) ? 3'd3 : (c == 2) ? 3'd4 : 3'd0)) begin bad++; $display("FAIL max_exit road=%0d step=%0d got=%0d", r, c, state); end
      end
    end
  endtask

  task automatic test_preempt();
    do_clear();
    density = 12'b000_000_000_001;
    tick(); tick();
    siren = 4'b1000;
    tick();
    total++; if (state !== 3'd3 || active_road !== 2'd0) begin bad++; $display("FAIL preempt_yield got=%0d/%0d exp=3/0", state, active_road); end
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL preempt_yellow2 got=%0d exp=3", state); end
    tick();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL preempt_allred got=%0d exp=4", state); end
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL preempt_idle got=%0d exp=0", state); end
    tick();
    total++; if (state !== 3'd5 || active_road !== 2'd3) begin bad++; $display("FAIL preempt_enter got=%0d/%0d exp=5/3", state, active_road); end
    total++; if (lights !== 12'b001100100100) begin bad++; $display("FAIL preempt_lights got=%b exp=001100100100", lights); end
    siren = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (state !== 3'd5 || active_road !== 2'd3) begin bad++; $display("FAIL preempt_hold cyc=%0d got=%0d/%0d exp=5/3", c, state, active_road); end
    end
    siren = 4'b0000;
    tick();
    total++; if (state !== 3'd3 || active_road !== 2'd3) begin bad++; $display("FAIL preempt_drop got=%0d/%0d exp=3/3", state, active_road); end
  endtask

  task automatic test_camera();
    do_clear();
    violation = 4'b0010;
    tick();
    total++; if (camera !== 4'b0010) begin bad++; $display("FAIL camera_red got=%b exp=0010", camera); end
    violation = 4'b0000;
    tick();
    total++; if (camera !== 4'b0000) begin bad++; $display("FAIL camera_pulse got=%b exp=0000", camera); end
    density = 12'b000_000_000_001;
    tick(); tick();
    violation = 4'b0001;
    tick();
    total++; if (camera !== 4'b0000) begin bad++; $display("FAIL camera_green got=%b exp=0000", camera); end
    violation = 4'b0000;
  endtask

  task automatic test_mid_clear();
    do_clear();
    density = 12'b000_000_000_001;
    tick(); tick(); tick(); tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL midclr_pre got=%0d exp=2", state); end
    clear = 1'b1;
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL midclr_state got=%0d exp=0", state); end
    total++; if (lights !== ALL_RED_L) begin bad++; $display("FAIL midclr_lights got=%b exp=%b", lights, ALL_RED_L); end
    clear = 1'b0;
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      clear = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) density = 12'($urandom);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 59) == 0) siren[k] = ~siren[k];
      violation = 4'($urandom) & 4'($urandom);
      tick();
      total++;
      if (state !== 3'(m_st) || active_road !== 2'(m_road) || lights !== m_lights() || camera !== m_cam) begin
        bad++;
        $display("FAIL random cyc=%0d got st=%0d road=%0d lights=%b cam=%b exp st=%0d road=%0d lights=%b cam=%b",
                 c, state, active_road, lights, camera, m_st, m_road, m_lights(), m_cam);
      end
    end
  endtask

  initial begin
    clear = 1'b1; density = '0; siren = '0; violation = '0;
    m_st = 0; m_road = 0; m_gcnt = 0; m_left = 0; m_last = N - 1; m_cam = '0;
    test_reset();
    test_single_road();
    test_min_green();
    test_max_green();
    test_preempt();
    test_camera();
    test_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
